// File: rtl/div_pkg.sv
// Shared constants and encodings for the iterative divider.
package div_pkg;

  localparam int DIV_XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference if non-negative.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] div_i,
  input  logic            bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_i < div_i always holds, so the shifted value fits in XLEN+1 bits and
  // the top bit of the difference is a reliable sign.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, div_i};
  assign q_o     = ~diff[XLEN];
  assign rem_o   = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/div_iter.sv
// Iterative RISC-V DIV/DIVU/REM/REMU: 32 restoring steps in CALC, sign fix-up
// in FIX, one-cycle done pulse in DONE. Divide-by-zero and overflow bypass CALC.
module div_iter
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] y
);

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [XLEN-1:0] y_q, y_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic            spec_q, spec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [XLEN-1:0] step_rem;
  logic            step_q;
  logic            signed_op;
  logic            in_sa, in_sb;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            b_zero, ovf;
  logic [XLEN-1:0] quo_fix, rem_fix;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .div_i (div_q),
    .bit_i (quo_q[XLEN-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign signed_op = (op == OP_DIV) || (op == OP_REM);
  assign in_sa     = signed_op & a[XLEN-1];
  assign in_sb     = signed_op & b[XLEN-1];
  assign abs_a     = in_sa ? -a : a;
  assign abs_b     = in_sb ? -b : b;
  assign b_zero    = (b == '0);
  assign ovf       = signed_op && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

  // Signed results: quotient sign is sa^sb, remainder follows the dividend.
  assign quo_fix = (op_q == OP_DIV && (sa_q ^ sb_q)) ? -quo_q : quo_q;
  assign rem_fix = (op_q == OP_REM && sa_q) ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    spec_d  = spec_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          sa_d  = in_sa;
          sb_d  = in_sb;
          div_d = abs_b;
          cnt_d = '0;
          if (b_zero) begin
            spec_d  = 1'b1;
            quo_d   = '1;
            rem_d   = a;
            state_d = S_FIX;
          end else if (ovf) begin
            spec_d  = 1'b1;
            quo_d   = {1'b1, {(XLEN-1){1'b0}}};
            rem_d   = '0;
            state_d = S_FIX;
          end else begin
            spec_d  = 1'b0;
            quo_d   = abs_a;
            rem_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        // quo_q doubles as the dividend shift register: MSB out, quotient bit in.
        rem_d = step_rem;
        quo_d = {quo_q[XLEN-2:0], step_q};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (spec_q) y_d = op_q[1] ? rem_q : quo_q;
        else        y_d = op_q[1] ? rem_fix : quo_fix;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      y_d     = y_q;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      spec_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      spec_q  <= spec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases, flush/reset/ignored
// start scenarios and random operations against an arithmetic reference model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] y;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_y;

  div_iter #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .flush (flush),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] d);
    int sx;
    int sd;
    logic ov;
    sx = x;
    sd = d;
    ov = (x == 32'h8000_0000) && (d == 32'hFFFF_FFFF);
    case (o)
      2'd0:    return (d == 0) ? 32'hFFFF_FFFF : (ov ? 32'h8000_0000 : 32'(sx / sd));
      2'd1:    return (d == 0) ? 32'hFFFF_FFFF : x / d;
      2'd2:    return (d == 0) ? x : (ov ? 32'h0 : 32'(sx % sd));
      default: return (d == 0) ? x : x % d;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] d);
    if (d == 0) return 2;
    if (!o[0] && x == 32'h8000_0000 && d == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the
  // following IDLE cycle. poke>0 re-pulses start with other operands at that cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input int poke, input string tag);
    int lat;
    logic [31:0] e;
    e = model(o, aa, bb);
    start = 1'b1; op = o; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    while (!done && lat < 100) begin
      if (lat == poke) begin
        start = 1'b1; a = 32'd1000; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, lat, exp_lat(o, aa, bb));
    chk({tag, "_y"}, y, e);
    last_y = e;
    @(negedge clk);
    chk({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int seen;
    logic [31:0] ra, rb, rr;
    logic [1:0]  ro;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    last_y = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {busy, done, y}, 34'd0);
    rst = 1'b0;

    // First op starts on the first edge after reset release.
    do_op(2'b01, 32'd100, 32'd7, 0, "divu_100_7");
    do_op(2'b11, 32'd100, 32'd7, 0, "remu_100_7");
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0, "div_neg7_2");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "rem_neg7_2");
    do_op(2'b00, 32'd7, 32'hFFFF_FFFE, 0, "div_7_neg2");
    do_op(2'b01, 32'd5, 32'd0, 0, "divu_by0");
    do_op(2'b10, 32'd5, 32'd0, 0, "rem_by0");
    do_op(2'b00, 32'd5, 32'd0, 0, "div_by0");
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");

    // Start pulsed mid-CALC must be ignored.
    do_op(2'b01, 32'd100, 32'd7, 10, "divu_ignore_start");

    // Flush at CALC cycle 20.
    start = 1'b1; op = 2'b00; a = 32'd12345; b = 32'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_y_held", y, last_y);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("flush_no_done", seen, 0);
    do_op(2'b01, 32'd100, 32'd7, 0, "divu_after_flush");

    // Flush wins over a simultaneous start.
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd9; b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_beats_start", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-CALC.
    start = 1'b1; op = 2'b01; a = 32'd999; b = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("arst_outputs", {busy, done, y}, 34'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(2'b01, 32'd100, 32'd7, 0, "divu_after_rst");

    // Random operations, biased towards the corner divisors.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rr = $urandom;
      ro = rr[1:0];
      case (rr[5:3])
        3'd0: rb = 32'd0;
        3'd1: rb = {28'd0, rb[3:0]};
        3'd2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3'd3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(ro, ra, rb, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
